// File: rtl/exc_pkg.sv
// Shared exception-controller types: FSM states, ESR cause codes and the default handler vector.
// Constants only; no timing or flow control of its own.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam logic [3:0] ESR_IRQ     = 4'b0001;
  localparam logic [3:0] ESR_UNDEF   = 4'b0010;
  localparam logic [3:0] ESR_BADERET = 4'b0100;
  localparam logic [3:0] ESR_DFAULT  = 4'b1000;

  localparam logic [63:0] VECTOR_ADDR_DFLT = 64'h0000_0000_0000_00D8;

  // Flush length is 1..7, so a 3-bit counter covers every legal setting.
  localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/flush_counter.sv
// Loadable down-counter; done_o is high during the last counted cycle (count == 1).
// Load takes effect on the next edge; no backpressure, it just counts while en_i is high.
module flush_counter
  import exc_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic [FLUSH_CNT_W-1:0] load_val_i,
  input  logic                   en_i,
  output logic                   done_o
);

  logic [FLUSH_CNT_W-1:0] cnt_q;
  logic [FLUSH_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == {{(FLUSH_CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: captures ELR/ESR, redirects PC to the vector or back to ELR, drives flush.
// Event on edge k -> redirect pulse in cycle k+1, flush for FLUSH_CYCLES cycles; no backpressure, all outputs registered.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned    N            = 64,
  parameter logic [N-1:0]   VECTOR_ADDR  = N'(VECTOR_ADDR_DFLT),
  parameter int unsigned    FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid,
  input  logic         Exc,
  input  logic         ERet,
  input  logic [3:0]   EStatus,
  input  logic         ExtIRQ,
  input  logic [N-1:0] pc_in,
  output logic         redirect,
  output logic [N-1:0] redirect_pc,
  output logic         flush,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic         in_handler,
  output logic         irq_pending,
  output logic         fatal
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_e       state_q, state_d;
  state_e       dest_q, dest_d;
  logic         redirect_q, redirect_d;
  logic [N-1:0] redirect_pc_q, redirect_pc_d;
  logic         flush_q, flush_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         in_handler_q, in_handler_d;
  logic         irq_pending_q, irq_pending_d;
  logic         fatal_q, fatal_d;

  logic         cnt_load;
  logic         cnt_en;
  logic         cnt_done;
  logic         take_entry;

  flush_counter u_flush_counter (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .load_i     (cnt_load),
    .load_val_i (FLUSH_LOAD),
    .en_i       (cnt_en),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = flush_q;
    elr_d         = elr_q;
    esr_d         = esr_q;
    in_handler_d  = in_handler_q;
    fatal_d       = fatal_q;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    take_entry    = 1'b0;
    // IRQs latch whenever unmasked, independent of the FSM state.
    irq_pending_d = irq_pending_q | (ExtIRQ & ~in_handler_q);

    case (state_q)
      RUN: begin
        if (instr_valid && Exc) begin
          elr_d      = pc_in;
          esr_d      = EStatus;
          take_entry = 1'b1;
        end else if (instr_valid && ERet) begin
          elr_d      = pc_in;
          esr_d      = ESR_BADERET;
          take_entry = 1'b1;
        end else if (irq_pending_q) begin
          elr_d         = pc_in;
          esr_d         = ESR_IRQ;
          irq_pending_d = 1'b0;
          take_entry    = 1'b1;
        end
        if (take_entry) begin
          state_d       = FLUSH;
          dest_d        = HANDLER;
          redirect_d    = 1'b1;
          redirect_pc_d = VECTOR_ADDR;
          flush_d       = 1'b1;
          cnt_load      = 1'b1;
        end
      end

      FLUSH: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          state_d      = dest_q;
          flush_d      = 1'b0;
          in_handler_d = (dest_q == HANDLER);
        end
      end

      HANDLER: begin
        // A fault inside the handler has no safe resume point, so it is terminal.
        if (instr_valid && Exc) begin
          state_d = HALT;
          fatal_d = 1'b1;
          esr_d   = ESR_DFAULT;
          flush_d = 1'b1;
        end else if (instr_valid && ERet) begin
          state_d       = FLUSH;
          dest_d        = RUN;
          redirect_d    = 1'b1;
          redirect_pc_d = elr_q;
          flush_d       = 1'b1;
          cnt_load      = 1'b1;
          in_handler_d  = 1'b0;
        end
      end

      HALT: begin
        flush_d = 1'b1;
        fatal_d = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      dest_q        <= RUN;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      elr_q         <= '0;
      esr_q         <= '0;
      in_handler_q  <= 1'b0;
      irq_pending_q <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_q        <= dest_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      elr_q         <= elr_d;
      esr_q         <= esr_d;
      in_handler_q  <= in_handler_d;
      irq_pending_q <= irq_pending_d;
      fatal_q       <= fatal_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = flush_q;
  assign elr         = elr_q;
  assign esr         = esr_q;
  assign in_handler  = in_handler_q;
  assign irq_pending = irq_pending_q;
  assign fatal       = fatal_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with a redirect scoreboard; flush length 3 to exercise multi-cycle flush and mid-flush reset.
module tb_exc_ctrl;
  import exc_pkg::*;

  localparam int unsigned FC = 3;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        exc;
  logic        eret;
  logic [3:0]  estatus;
  logic        ext_irq;
  logic [63:0] pc_in;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [63:0] elr;
  logic [3:0]  esr;
  logic        in_handler;
  logic        irq_pending;
  logic        fatal;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] elr;
    logic [3:0]  esr;
  } exp_t;

  exp_t exp_q[$];

  exc_ctrl #(
    .N            (64),
    .VECTOR_ADDR  (64'h0000_0000_0000_00D8),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .instr_valid (instr_valid),
    .Exc         (exc),
    .ERet        (eret),
    .EStatus     (estatus),
    .ExtIRQ      (ext_irq),
    .pc_in       (pc_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .elr         (elr),
    .esr         (esr),
    .in_handler  (in_handler),
    .irq_pending (irq_pending),
    .fatal       (fatal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    exc         = 1'b0;
    eret        = 1'b0;
    estatus     = 4'b0000;
    ext_irq     = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [63:0] e_elr, input logic [3:0] e_esr);
    exp_t e;
    e.pc  = pc;
    e.elr = e_elr;
    e.esr = e_esr;
    exp_q.push_back(e);
  endtask

  // Called in the first flush cycle; walks the rest of the flush and checks the landing state.
  task automatic flush_seq(input logic to_handler);
    for (int i = 1; i < int'(FC); i++) begin
      tick();
      chk("flush_hold", 64'(flush), 64'd1);
      chk("redirect_single", 64'(redirect), 64'd0);
      chk("in_handler_during_flush", 64'(in_handler), 64'd0);
    end
    tick();
    chk("flush_end", 64'(flush), 64'd0);
    chk("in_handler_after_flush", 64'(in_handler), 64'(to_handler));
  endtask

  always @(negedge clk) begin
    if (redirect === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL unexpected_redirect: observed redirect_pc %0h expected no redirect", redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_redirect_pc", redirect_pc, e.pc);
        chk("sb_elr", elr, e.elr);
        chk("sb_esr", 64'(esr), 64'(e.esr));
        chk("sb_flush", 64'(flush), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pc_in = 64'h0;
    idle();
    tick();
    tick();
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_elr", elr, 64'd0);
    chk("rst_esr", 64'(esr), 64'd0);
    chk("rst_in_handler", 64'(in_handler), 64'd0);
    chk("rst_irq_pending", 64'(irq_pending), 64'd0);
    chk("rst_fatal", 64'(fatal), 64'd0);
    rst_n = 1'b1;
    tick();

    // Undefined op entry
    instr_valid = 1'b1; exc = 1'b1; estatus = ESR_UNDEF; pc_in = 64'h40;
    push_exp(64'hD8, 64'h40, ESR_UNDEF);
    tick();
    idle();
    chk("t1_redirect", 64'(redirect), 64'd1);
    chk("t1_redirect_pc", redirect_pc, 64'hD8);
    chk("t1_flush", 64'(flush), 64'd1);
    chk("t1_elr", elr, 64'h40);
    chk("t1_esr", 64'(esr), 64'(ESR_UNDEF));
    flush_seq(1'b1);

    // Return
    instr_valid = 1'b1; eret = 1'b1; pc_in = 64'h200;
    push_exp(64'h40, 64'h40, ESR_UNDEF);
    tick();
    idle();
    chk("t2_redirect_pc", redirect_pc, 64'h40);
    chk("t2_in_handler", 64'(in_handler), 64'd0);
    chk("t2_elr", elr, 64'h40);
    chk("t2_esr", 64'(esr), 64'(ESR_UNDEF));
    flush_seq(1'b0);

    // IRQ latch and entry
    ext_irq = 1'b1; pc_in = 64'h100;
    tick();
    idle();
    chk("t3_irq_latched", 64'(irq_pending), 64'd1);
    chk("t3_no_early_redirect", 64'(redirect), 64'd0);
    push_exp(64'hD8, 64'h100, ESR_IRQ);
    tick();
    chk("t3_redirect", 64'(redirect), 64'd1);
    chk("t3_elr", elr, 64'h100);
    chk("t3_esr", 64'(esr), 64'(ESR_IRQ));
    chk("t3_irq_cleared", 64'(irq_pending), 64'd0);
    flush_seq(1'b1);
    ext_irq = 1'b1;
    tick();
    ext_irq = 1'b0;
    chk("t3_irq_masked", 64'(irq_pending), 64'd0);
    tick();
    chk("t3_irq_masked2", 64'(irq_pending), 64'd0);
    instr_valid = 1'b1; eret = 1'b1;
    push_exp(64'h100, 64'h100, ESR_IRQ);
    tick();
    idle();
    flush_seq(1'b0);

    // Exc and IRQ collide
    instr_valid = 1'b1; exc = 1'b1; estatus = ESR_UNDEF; ext_irq = 1'b1; pc_in = 64'h300;
    push_exp(64'hD8, 64'h300, ESR_UNDEF);
    tick();
    idle();
    chk("t4_esr", 64'(esr), 64'(ESR_UNDEF));
    chk("t4_irq_kept", 64'(irq_pending), 64'd1);
    flush_seq(1'b1);
    chk("t4_irq_kept_handler", 64'(irq_pending), 64'd1);
    instr_valid = 1'b1; eret = 1'b1; pc_in = 64'h340;
    push_exp(64'h300, 64'h300, ESR_UNDEF);
    tick();
    idle();
    flush_seq(1'b0);
    push_exp(64'hD8, 64'h340, ESR_IRQ);
    tick();
    chk("t4_irq_redirect", 64'(redirect), 64'd1);
    chk("t4_irq_esr", 64'(esr), 64'(ESR_IRQ));
    chk("t4_irq_elr", elr, 64'h340);
    chk("t4_irq_cleared", 64'(irq_pending), 64'd0);
    flush_seq(1'b1);
    instr_valid = 1'b1; eret = 1'b1;
    push_exp(64'h340, 64'h340, ESR_IRQ);
    tick();
    idle();
    flush_seq(1'b0);

    // Illegal return, then double fault
    instr_valid = 1'b1; eret = 1'b1; pc_in = 64'h80;
    push_exp(64'hD8, 64'h80, ESR_BADERET);
    tick();
    idle();
    chk("t5_esr", 64'(esr), 64'(ESR_BADERET));
    chk("t5_elr", elr, 64'h80);
    flush_seq(1'b1);
    instr_valid = 1'b1; exc = 1'b1; estatus = ESR_UNDEF; pc_in = 64'h90;
    tick();
    idle();
    chk("t5_fatal", 64'(fatal), 64'd1);
    chk("t5_esr_dfault", 64'(esr), 64'(ESR_DFAULT));
    chk("t5_elr_kept", elr, 64'h80);
    chk("t5_flush", 64'(flush), 64'd1);
    instr_valid = 1'b1; eret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_halt_flush", 64'(flush), 64'd1);
      chk("t5_halt_fatal", 64'(fatal), 64'd1);
      chk("t5_halt_redirect", 64'(redirect), 64'd0);
    end
    idle();

    // Reset out of HALT, then reset in the middle of a flush
    rst_n = 1'b0;
    tick();
    chk("t6_halt_rst_fatal", 64'(fatal), 64'd0);
    chk("t6_halt_rst_flush", 64'(flush), 64'd0);
    rst_n = 1'b1;
    instr_valid = 1'b1; exc = 1'b1; estatus = ESR_UNDEF; pc_in = 64'h500;
    push_exp(64'hD8, 64'h500, ESR_UNDEF);
    tick();
    idle();
    chk("t6_redirect", 64'(redirect), 64'd1);
    tick();
    chk("t6_mid_flush", 64'(flush), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_redirect", 64'(redirect), 64'd0);
    chk("t6_rst_flush", 64'(flush), 64'd0);
    chk("t6_rst_elr", elr, 64'd0);
    chk("t6_rst_esr", 64'(esr), 64'd0);
    chk("t6_rst_in_handler", 64'(in_handler), 64'd0);
    chk("t6_rst_redirect_pc", redirect_pc, 64'd0);
    for (int i = 0; i < int'(FC) + 2; i++) begin
      tick();
      chk("t6_no_redirect", 64'(redirect), 64'd0);
      chk("t6_no_flush", 64'(flush), 64'd0);
    end
    instr_valid = 1'b1; exc = 1'b1; estatus = ESR_UNDEF; pc_in = 64'h600;
    push_exp(64'hD8, 64'h600, ESR_UNDEF);
    tick();
    idle();
    chk("t6_reentry_redirect", 64'(redirect), 64'd1);
    chk("t6_reentry_elr", elr, 64'h600);
    flush_seq(1'b1);

    tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Sequential exception/interrupt controller that consumes the main decoder's exception outputs (Exc, ERet, EStatus) plus the raw ExtIRQ line.
- Sits beside the PC logic of the LEGv8 core. Captures ELR/ESR, issues the PC redirect to the handler vector or back to ELR, drives pipeline flush, and tracks handler mode.
- Closes the loop that the decoder opens: the decoder flags events, this block executes exception entry and return.

Parameters:
- N, 64, PC/ELR width.
- VECTOR_ADDR, 64'h0000_0000_0000_00D8, handler entry address.
- FLUSH_CYCLES, 1, cycles flush stays asserted after entry or return (1..7).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- instr_valid  in  1  decoder outputs are valid this cycle.
- Exc  in  1  decoder exception request.
- ERet  in  1  decoder ERET instruction.
- EStatus  in  4  decoder exception cause.
- ExtIRQ  in  1  external interrupt, level, asynchronous to instruction flow.
- pc_in  in  N  PC of the instruction currently being decoded.
- redirect  out  1  one-cycle pulse: PC must load redirect_pc.
- redirect_pc  out  N  VECTOR_ADDR on entry, ELR on return.
- flush  out  1  squash in-flight instructions.
- elr  out  N  exception link register.
- esr  out  4  exception syndrome register.
- in_handler  out  1  handler mode; IRQs masked.
- irq_pending  out  1  latched unserviced IRQ.
- fatal  out  1  sticky double-fault indicator.

Behaviour:
- Reset (reset==0 at a rising edge): all outputs 0, elr=0, esr=0, state RUN, flush counter 0. Reset mid-FLUSH aborts the sequence; no redirect is issued.
- States:
  - RUN: normal execution.
  - FLUSH: counting FLUSH_CYCLES.
  - HANDLER: executing the handler.
  - HALT: after a fatal event.
- irq_pending: set on any cycle with ExtIRQ==1 and in_handler==0. Cleared only when the IRQ is taken. ExtIRQ while in_handler==1 is ignored, not latched.
- RUN, accepted events (only when instr_valid==1, except IRQ), in priority order:
  1. Exc: elr<=pc_in, esr<=EStatus, enter FLUSH with target VECTOR_ADDR and dest HANDLER.
  2. ERet in RUN (illegal return): elr<=pc_in, esr<=4'b0100, then same as 1.
  3. irq_pending (instr_valid not required): elr<=pc_in (resume point), esr<=4'b0001, clear irq_pending, then same as 1.
- HANDLER:
  - ERet & instr_valid: enter FLUSH with target elr and dest RUN. elr/esr are unchanged.
  - Exc & instr_valid (nested): fatal<=1, esr<=4'b1000, elr unchanged, go to HALT.
- FLUSH:
  - Cycle after the accepting edge: redirect=1 for exactly one cycle, with redirect_pc = target.
  - flush=1 for FLUSH_CYCLES consecutive cycles starting in that same cycle.
  - All inputs except ExtIRQ latching are ignored.
  - Leaves to dest on the edge ending the last flush cycle.
- in_handler: 1 on the cycle after leaving FLUSH into HANDLER. Cleared on the cycle a return FLUSH begins. IRQ latching is re-enabled from that point.
- HALT: flush=1 continuously, redirect=0, fatal=1. Exits only on reset.
- Latency: event on edge k gives redirect in cycle k+1; the handler's first instruction is decoded in cycle k+1+FLUSH_CYCLES.
- Simultaneous Exc and IRQ: Exc is taken and IRQ stays pending. After return it is taken in the first RUN cycle.
- Exc and ERet asserted together: Exc wins.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package exc_pkg:
  - state enum {RUN, FLUSH, HANDLER, HALT}.
  - ESR cause constants: ESR_IRQ=4'b0001, ESR_UNDEF=4'b0010, ESR_BADERET=4'b0100, ESR_DFAULT=4'b1000.
  - Default VECTOR_ADDR.
- The decoder and its testbench import the same cause constants.
- Single sub-module flush_counter: loadable down-counter with a done flag. Everything else stays inline.

Test Plan:
1. Undefined op: in RUN, instr_valid=1, Exc=1, EStatus=4'b0010, pc_in=64'h40 → next cycle redirect=1, redirect_pc=64'hD8, flush=1; elr=64'h40, esr=4'b0010; in_handler=1 one cycle later.
2. Return: from test 1 state, ERet=1, instr_valid=1 → redirect_pc=64'h40, flush for FLUSH_CYCLES, in_handler=0, elr/esr unchanged.
3. IRQ: ExtIRQ pulsed one cycle with pc_in=64'h100 and no Exc → irq_pending=1, then entry with elr=64'h100, esr=4'b0001, irq_pending=0. A second ExtIRQ pulse inside the handler → irq_pending stays 0.
4. Collision: Exc (EStatus=0010) and ExtIRQ in the same cycle → esr=0010, irq_pending stays 1. After ERet completes, a second entry occurs with esr=0001.
5. Faults: ERet in RUN at pc_in=64'h80 → esr=4'b0100, elr=64'h80. A nested Exc in HANDLER → fatal=1, esr=4'b1000, flush held at 1 until reset.
6. Reset: reset=0 during a FLUSH cycle with FLUSH_CYCLES=3 → all outputs 0 on the next cycle, no further redirect; normal Exc entry works after reset=1.
